miyajiro_uart_tx: RTL and testbench

Byte-oriented UART transmitter (8N1, LSB first) with an internal write FIFO. The MIYAJIRO_CPU core uses it as its console/result output channel. The CPU pushes bytes through a single-cycle write strobe. The block serializes them on `tx` for an external receiver, either a host or the system testbench's UART monitor.

---
 rtl/miyajiro_uart_tx.sv | 81 ++++++++
 tb/tb_miyajiro_uart_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/miyajiro_uart_tx.sv
// miyajiro_uart_tx: 8N1 LSB-first UART transmitter fed by a circular write FIFO.
module miyajiro_uart_tx #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic [FIFO_DEPTH_LOG2:0] count,
  output logic                     busy,
  output logic                     overflow,
  output logic                     tx
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int BW    = CLKS_PER_BIT > 2 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t                     state_q, state_d;
  logic [BW-1:0]              baud_q, baud_d;
  logic [2:0]                 bit_q, bit_d;
  logic [7:0]                 shift_q, shift_d;
  logic [FIFO_DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       overflow_q, overflow_d, tx_q, tx_d;
  logic [7:0]                 mem_q [DEPTH];
  logic                       term, push, pop;
  always_comb begin
    term       = baud_q == BW'(CLKS_PER_BIT - 1);
    push       = wr_en && !full;
    pop        = count_q != '0 && (state_q == IDLE || (state_q == STOP && term));
    baud_d     = (state_q == IDLE || term) ? '0 : baud_q + 1'b1;
    bit_d      = (state_q == IDLE || pop) ? '0 : (state_q == DATA && term) ? bit_q + 3'd1 : bit_q;
    shift_d    = pop ? mem_q[rptr_q] : (state_q == DATA && term) ? shift_q >> 1 : shift_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    wptr_d     = wptr_q + FIFO_DEPTH_LOG2'(push);
    rptr_d     = rptr_q + FIFO_DEPTH_LOG2'(pop);
    overflow_d = overflow_q || (wr_en && full);
    state_d    = state_q;
    case (state_q)
      IDLE:  state_d = pop ? START : IDLE;
      START: state_d = term ? DATA : START;
      DATA:  state_d = (term && bit_q == 3'd7) ? STOP : DATA;
      STOP:  state_d = term ? (pop ? START : IDLE) : STOP;
    endcase
    // tx is registered, so it is computed from the state being entered
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_q       <= tx_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end
  assign full     = count_q == CW'(DEPTH);
  assign count    = count_q;
  assign busy     = state_q != IDLE || count_q != '0;
  assign overflow = overflow_q;
  assign tx       = tx_q;
endmodule

// File: tb/tb_miyajiro_uart_tx.sv
// tb_miyajiro_uart_tx: directed writes feed an expected-byte queue; a serial monitor decodes tx and checks it.
module tb_miyajiro_uart_tx;
  logic       clk, reset, wr_en, full, busy, overflow, tx;
  logic [7:0] wr_data;
  logic [2:0] count;
  int         checks = 0, failures = 0, cyc = 0, nframes = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  miyajiro_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .count(count), .busy(busy), .overflow(overflow), .tx(tx)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic wr(input logic [7:0] b, input bit push);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = b;
    if (push) exp_q.push_back(b);
  endtask
  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask
  task automatic rx_frame();
    logic [7:0] b;
    int t0;
    t0 = cyc;
    repeat (2) begin @(negedge clk); if (reset) return; end
    chk("start_bit", tx, 1'b0);
    for (int j = 0; j < 8; j++) begin
      repeat (4) begin @(negedge clk); if (reset) return; end
      b[j] = tx;
    end
    repeat (4) begin @(negedge clk); if (reset) return; end
    chk("stop_bit", tx, 1'b1);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_frame actual=%0h required=none", b);
    end else chk("rx_byte", b, exp_q.pop_front());
    starts.push_back(t0);
    nframes++;
    @(negedge clk);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) rx_frame();
    end
  end
  initial begin
    int n, f0;
    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_full", full, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    // single byte: tx falls one edge after the accepting edge, frame is 40 cycles
    wr(8'h55, 1);
    @(negedge clk);
    wr_en = 1'b0;
    chk("single_count_after_write", count, 3'd1);
    chk("single_tx_still_idle", tx, 1'b1);
    chk("single_busy", busy, 1'b1);
    @(negedge clk);
    chk("single_tx_start", tx, 1'b0);
    chk("single_count_popped", count, 3'd0);
    wait_idle(100, n);
    chk("single_frame_len", n, 40);
    chk("single_busy_done", busy, 1'b0);
    chk("single_queue_drained", exp_q.size(), 0);
    // back-to-back frames
    f0 = nframes;
    wr(8'hA3, 1);
    wr(8'h0F, 1);
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle(200, n);
    chk("b2b_busy_done", busy, 1'b0);
    chk("b2b_frames", nframes - f0, 2);
    chk("b2b_gap", starts[$] - starts[$-1], 40);
    chk("b2b_queue_drained", exp_q.size(), 0);
    // full and overflow
    f0 = nframes;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        chk("full_flag", full, 1'b1);
        chk("full_count", count, 3'd4);
      end
      wr_en = 1'b1;
      wr_data = 8'h10 + 8'(i);
      if (i < 5) exp_q.push_back(wr_data);
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("overflow_set", overflow, 1'b1);
    chk("overflow_count_kept", count, 3'd4);
    wait_idle(400, n);
    chk("full_busy_done", busy, 1'b0);
    chk("full_frames", nframes - f0, 5);
    chk("full_queue_drained", exp_q.size(), 0);
    chk("overflow_sticky", overflow, 1'b1);
    // write lands on the same edge as the stop-bit-end pop
    wr(8'hC1, 1);
    @(negedge clk);
    wr_en = 1'b0;
    wr(8'hC2, 1);
    @(negedge clk);
    wr_en = 1'b0;
    repeat (38) @(negedge clk);
    chk("simul_count_before", count, 3'd1);
    wr_en = 1'b1;
    wr_data = 8'hC3;
    exp_q.push_back(8'hC3);
    @(negedge clk);
    wr_en = 1'b0;
    chk("simul_count_after", count, 3'd1);
    chk("simul_next_start", tx, 1'b0);
    wait_idle(200, n);
    chk("simul_busy_done", busy, 1'b0);
    chk("simul_gap", starts[$] - starts[$-1], 40);
    chk("simul_queue_drained", exp_q.size(), 0);
    // reset during data bit 3 of a 0x00 frame with one byte still queued
    f0 = nframes;
    wr(8'h00, 1);
    wr(8'h5A, 1);
    @(negedge clk);
    wr_en = 1'b0;
    repeat (17) @(negedge clk);
    chk("midrst_tx_low_before", tx, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_tx_async", tx, 1'b1);
    chk("midrst_count", count, 3'd0);
    chk("midrst_overflow", overflow, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("midrst_no_frames", nframes - f0, 0);
    chk("midrst_tx_idle", tx, 1'b1);
    chk("midrst_busy_after", busy, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
